jedro_1_lsu: RTL and testbench
==============================

JEDRO_1_LSU -- requirements
Module: jedro_1_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus and register width; only 32 is supported.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: width of the destination register address.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum cycles a transaction may stay outstanding; 0 disables the timeout.
REQ-004 Clock and reset SHALL be one clock with a synchronous, active-high reset.
REQ-005 Port: clk_i, input, 1: clock; all state updates on the rising edge.
REQ-006 Port: rst_i, input, 1: synchronous, active-high reset.
REQ-007 Port: lsu_new_ctrl_i, input, 1: request strobe from the decoder/FSM.
REQ-008 Port: lsu_ctrl_i, input, 4: bit3 = store, bits[2:0] = RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Port: lsu_regdest_i, input, REG_ADDR_WIDTH: load destination register.
REQ-010 Port: lsu_addr_i, input, DATA_WIDTH: effective byte address.
REQ-011 Port: lsu_wdata_i, input, DATA_WIDTH: store data, right-aligned.
REQ-012 Port: lsu_busy_o, output, 1: high in any non-IDLE state.
REQ-013 Port: rf_wb_o / rf_addr_o / rf_data_o, outputs, 1 / REG_ADDR_WIDTH / DATA_WIDTH: load writeback.
REQ-014 Port: misaligned_o, output, 1: one-cycle exception pulse.
REQ-015 Port: bus_err_o, output, 1: one-cycle bus error or timeout pulse.
REQ-016 Port: data_req_o, data_we_o, data_be_o[3:0], data_addr_o, data_wdata_o, outputs: registered bus request.
REQ-017 Port: data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i[DATA_WIDTH-1:0], inputs: bus response.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-019 IDLE, lsu_new_ctrl_i=1, aligned access: all inputs SHALL be latched and the FSM SHALL go to REQ, with data_req_o=1 in the next cycle.
REQ-020 Alignment rule: H/HU requires addr[0]=0, W requires addr[1:0]=00; reserved funct3 values (011, 110, 111) SHALL count as misaligned.
REQ-021 A misaligned access SHALL stay in IDLE, issue no bus request, and pulse misaligned_o for one cycle in the next cycle.
REQ-022 data_addr_o SHALL be {addr[31:2],2'b00}.
REQ-023 data_be_o SHALL be: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-024 Store data SHALL be replicated: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W unchanged.
REQ-025 REQ state: data_req_o and the address/control outputs SHALL hold stable until the cycle where data_gnt_i=1; on gnt, next state WAIT and data_req_o=0.
REQ-026 WAIT state: on data_rvalid_i=1 with data_err_i=0, a load SHALL go to RESP and a store SHALL go to IDLE.
REQ-027 RESP state: rf_wb_o=1 for exactly one cycle, rf_addr_o = latched destination, then IDLE.
REQ-028 Load extraction: byte/halfword selected by addr[1:0]; B/H sign-extended; BU/HU zero-extended; W passed through.
REQ-029 On data_rvalid_i=1 with data_err_i=1, the LSU SHALL return to IDLE, pulse bus_err_o for one cycle, and not write back.
REQ-030 Timeout: a counter SHALL clear on accept and increment each cycle in REQ/WAIT; at TIMEOUT_CYCLES it SHALL drop data_req_o, pulse bus_err_o and go to IDLE.
REQ-031 lsu_new_ctrl_i while lsu_busy_o=1 SHALL be ignored; the earliest acceptance is the cycle after the return to IDLE.
REQ-032 data_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-033 Best-case latency: load writeback 3 cycles after accept (gnt and rvalid each 1 cycle); store busy for 2 cycles.
REQ-034 rf_wb_o, misaligned_o and bus_err_o SHALL never be high in the same cycle.

Reset
REQ-035 With rst_i=1 at a clock edge: state IDLE, counter 0, and all outputs 0 (data_be_o=0000, data_addr_o=0, rf_data_o=0).
REQ-036 Reset mid-transaction SHALL abort without writeback or error pulse; a later rvalid SHALL be ignored.

Verification
REQ-037 LW at 0x100, rdata=0xDEADBEEF, gnt and rvalid immediate -> be=1111, rf_wb_o 3 cycles after accept, rf_data_o=0xDEADBEEF.
REQ-038 LB at 0x103, rdata=0x80000000 -> rf_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-039 SH at 0x202, wdata=0x1234ABCD -> addr=0x200, be=1100, data_wdata_o=0xABCDABCD, no rf_wb_o.
REQ-040 LW at 0x101 -> no data_req_o, misaligned_o pulses once, lsu_busy_o stays 0.
REQ-041 gnt withheld, TIMEOUT_CYCLES=4 -> data_req_o stays high 4 cycles, then drops; bus_err_o pulses once; state IDLE.
REQ-042 rvalid with data_err_i=1 on a load, then rst_i asserted during a following REQ -> bus_err_o pulse, no writeback, all outputs reset next cycle.

Source files
------------

// File: rtl/jedro_1_lsu.sv
// -----------------------------------------------------------------------------
// jedro_1_lsu -- load/store unit for the Jedro-1 RV32I core.
//
// Takes one load or store request at a time from the decoder. It checks the
// alignment, issues a single bus transaction, and then either writes the
// extracted load result back to the register file or reports an error.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   lsu_new_ctrl_i          request strobe (ignored while lsu_busy_o=1)
//   lsu_ctrl_i[3:0]         bit3 = store, bits[2:0] = RV32I funct3
//   lsu_regdest_i           load destination register
//   lsu_addr_i              effective byte address
//   lsu_wdata_i             store data, right-aligned
//   lsu_busy_o              high in any non-IDLE state
//   rf_wb_o/rf_addr_o/rf_data_o   one-cycle load writeback
//   misaligned_o            one-cycle misaligned/illegal access pulse
//   bus_err_o               one-cycle bus error or timeout pulse
//   data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o  bus request
//   data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i           bus response
// -----------------------------------------------------------------------------
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      lsu_new_ctrl_i,
    input  logic [3:0]                lsu_ctrl_i,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_regdest_i,
    input  logic [DATA_WIDTH-1:0]     lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
    output logic                      lsu_busy_o,
    output logic                      rf_wb_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_data_o,
    output logic                      misaligned_o,
    output logic                      bus_err_o,
    output logic                      data_req_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_addr_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    input  logic                      data_err_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // The counter must be able to reach TIMEOUT_CYCLES-1 without wrapping.
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam int TO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      is_store_q;
    logic [2:0]                funct3_q;
    logic [1:0]                offset_q;
    logic [REG_ADDR_WIDTH-1:0] regdest_q;
    logic                      misaligned_q, bus_err_q;

    logic accept, misaligned_d, bus_err_d, load_done, timeout;

    // Halfword needs an even address, word needs a word address; reserved
    // funct3 encodings are rejected by the same path.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: is_misaligned = 1'b0;
            3'b001, 3'b101: is_misaligned = a[0];
            3'b010:         is_misaligned = (a != 2'b00);
            default:        is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_enable = 4'b0001 << a;
            2'b01:   byte_enable = 4'b0011 << a;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'b0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'b0, h};
            default: extract = d;
        endcase
    endfunction

    // A zero TIMEOUT_CYCLES disables the check entirely.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(TO_LIMIT));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        load_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lsu_new_ctrl_i) begin
                    if (is_misaligned(lsu_ctrl_i[2:0], lsu_addr_i[1:0])) begin
                        misaligned_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Timeout wins so a late grant can never extend the window.
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (data_rvalid_i) begin
                    if (data_err_i) begin
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (is_store_q) begin
                        state_d = IDLE;
                    end else begin
                        load_done = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            regdest_q    <= '0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
            rf_data_o    <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;

            if (accept) begin
                cnt_q        <= '0;
                is_store_q   <= lsu_ctrl_i[3];
                funct3_q     <= lsu_ctrl_i[2:0];
                offset_q     <= lsu_addr_i[1:0];
                regdest_q    <= lsu_regdest_i;
                data_addr_o  <= {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
                data_be_o    <= byte_enable(lsu_ctrl_i[1:0], lsu_addr_i[1:0]);
                data_wdata_o <= replicate(lsu_ctrl_i[1:0], lsu_wdata_i);
            end else if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load_done) begin
                rf_data_o <= extract(funct3_q, offset_q, data_rdata_i);
            end
        end
    end

    assign lsu_busy_o   = (state_q != IDLE);
    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = is_store_q;
    assign rf_wb_o      = (state_q == RESP);
    assign rf_addr_o    = regdest_q;
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_lsu -- self-checking bench for jedro_1_lsu (TIMEOUT_CYCLES = 4).
// Inputs change 1 ns after the rising edge; outputs are read at that point too,
// well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_jedro_1_lsu;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_new_ctrl_i = 1'b0;
    logic [3:0]  lsu_ctrl_i = '0;
    logic [4:0]  lsu_regdest_i = '0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_busy_o, rf_wb_o, misaligned_o, bus_err_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
    logic [31:0] data_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    jedro_1_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_new_ctrl_i(lsu_new_ctrl_i), .lsu_ctrl_i(lsu_ctrl_i),
        .lsu_regdest_i(lsu_regdest_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .rf_wb_o(rf_wb_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_misaligned(input int f3, input logic [31:0] a);
        if (f3 == 0 || f3 == 4) return 1'b0;
        if (f3 == 1 || f3 == 5) return (a % 2) != 0;
        if (f3 == 2)            return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
        int sz = f3 % 4;
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
        int sz = f3 % 4;
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] s = d >> (8 * (a % 4));
        logic [31:0] v;
        case (f3)
            0: begin v = s & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            4: v = s & 32'hFF;
            1: begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            5: v = s & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    // One complete aligned transaction. gd = grant delay, rvd = rvalid delay
    // after grant. With noise set, a misaligned garbage request is held on the
    // request inputs throughout busy and spurious rvalid appears before grant.
    task automatic do_txn(input string nm, input bit st, input int f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int gd, input int rvd, input bit err, input bit noise);
        logic [31:0] exp_addr = a & 32'hFFFF_FFFC;
        lsu_new_ctrl_i = 1'b1; lsu_ctrl_i = {st, 3'(f3)};
        lsu_regdest_i = rd; lsu_addr_i = a; lsu_wdata_i = wd;
        tick();
        lsu_new_ctrl_i = noise;
        if (noise) begin
            lsu_ctrl_i = 4'b0010; lsu_addr_i = a ^ 32'h0000_0101;
            lsu_wdata_i = ~wd; lsu_regdest_i = ~rd;
        end
        for (int i = 0; i <= gd; i++) begin
            data_rvalid_i = noise && (i < gd);
            data_gnt_i    = (i == gd);
            n_checks++;
            if (data_req_o !== 1'b1 || lsu_busy_o !== 1'b1 || misaligned_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s req: req=%b busy=%b mis=%b, required 1 1 0", nm, data_req_o, lsu_busy_o, misaligned_o);
            end
            n_checks++;
            if (data_addr_o !== exp_addr || data_be_o !== m_be(f3, a) || data_we_o !== st) begin
                n_fail++;
                $display("FAIL %s bus: addr=%h be=%b we=%b, required %h %b %b", nm, data_addr_o, data_be_o, data_we_o, exp_addr, m_be(f3, a), st);
            end
            if (st) begin
                n_checks++;
                if (data_wdata_o !== m_wdata(f3, wd)) begin
                    n_fail++;
                    $display("FAIL %s wdata: got %h, required %h", nm, data_wdata_o, m_wdata(f3, wd));
                end
            end
            tick();
        end
        data_gnt_i = 1'b0;
        for (int i = 0; i <= rvd; i++) begin
            data_rvalid_i = (i == rvd);
            data_err_i    = err;
            data_rdata_i  = (i == rvd) ? rdat : $urandom;
            n_checks++;
            if (data_req_o !== 1'b0 || lsu_busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s wait: req=%b busy=%b, required 0 1", nm, data_req_o, lsu_busy_o);
            end
            tick();
        end
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        if (err || st) lsu_new_ctrl_i = 1'b0;
        n_checks++;
        if (err) begin
            if (bus_err_o !== 1'b1 || rf_wb_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s err: err=%b wb=%b busy=%b, required 1 0 0", nm, bus_err_o, rf_wb_o, lsu_busy_o);
            end
        end else if (st) begin
            if (bus_err_o !== 1'b0 || rf_wb_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s store_done: err=%b wb=%b busy=%b, required 0 0 0", nm, bus_err_o, rf_wb_o, lsu_busy_o);
            end
        end else begin
            if (rf_wb_o !== 1'b1 || rf_addr_o !== rd || rf_data_o !== m_load(f3, a, rdat) ||
                bus_err_o !== 1'b0 || misaligned_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wb: wb=%b rd=%0d data=%h err=%b mis=%b, required 1 %0d %h 0 0",
                         nm, rf_wb_o, rf_addr_o, rf_data_o, bus_err_o, misaligned_o, rd, m_load(f3, a, rdat));
            end
            lsu_new_ctrl_i = 1'b0;
            tick();
            n_checks++;
            if (rf_wb_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s wb_end: wb=%b busy=%b, required 0 0", nm, rf_wb_o, lsu_busy_o);
            end
        end
        if (!(st && !err) && !err) begin
            // load path already advanced to IDLE above
        end else begin
            tick();
        end
        n_checks++;
        if (bus_err_o !== 1'b0 || misaligned_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: err=%b mis=%b busy=%b, required 0 0 0", nm, bus_err_o, misaligned_o, lsu_busy_o);
        end
    endtask

    task automatic do_misaligned(input string nm, input bit st, input int f3, input logic [31:0] a);
        lsu_new_ctrl_i = 1'b1; lsu_ctrl_i = {st, 3'(f3)}; lsu_addr_i = a;
        tick();
        lsu_new_ctrl_i = 1'b0;
        n_checks++;
        if (misaligned_o !== 1'b1 || data_req_o !== 1'b0 || lsu_busy_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: mis=%b req=%b busy=%b err=%b, required 1 0 0 0", nm, misaligned_o, data_req_o, lsu_busy_o, bus_err_o);
        end
        tick();
        n_checks++;
        if (misaligned_o !== 1'b0 || data_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after: mis=%b req=%b busy=%b, required 0 0 0", nm, misaligned_o, data_req_o, lsu_busy_o);
        end
    endtask

    task automatic check_all_zero(input string nm);
        n_checks++;
        if ({lsu_busy_o, rf_wb_o, misaligned_o, bus_err_o, data_req_o, data_we_o} !== 6'b0 ||
            data_be_o !== 4'b0 || data_addr_o !== 32'b0 || data_wdata_o !== 32'b0 ||
            rf_data_o !== 32'b0 || rf_addr_o !== 5'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b wb=%b mis=%b err=%b req=%b we=%b be=%b addr=%h wd=%h rfd=%h rfa=%0d, required all 0",
                     nm, lsu_busy_o, rf_wb_o, misaligned_o, bus_err_o, data_req_o, data_we_o,
                     data_be_o, data_addr_o, data_wdata_o, rf_data_o, rf_addr_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();
        check_all_zero("reset_release");
    endtask

    task automatic test_directed();
        do_txn("lw_0x100", 1'b0, 2, 5'd7, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        do_txn("lb_0x103", 1'b0, 0, 5'd3, 32'h103, 32'h0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        do_txn("lbu_0x103", 1'b0, 4, 5'd4, 32'h103, 32'h0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        do_txn("sh_0x202", 1'b1, 1, 5'd0, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0, 1'b0);
        do_misaligned("lw_0x101", 1'b0, 2, 32'h101);
        do_misaligned("lh_0x201", 1'b0, 1, 32'h201);
        do_misaligned("reserved_011", 1'b0, 3, 32'h300);
    endtask

    task automatic test_latency();
        // Best case: writeback exactly 3 cycles after the accept edge.
        int wb_cycle = -1;
        lsu_new_ctrl_i = 1'b1; lsu_ctrl_i = 4'b0010; lsu_addr_i = 32'h40; lsu_regdest_i = 5'd9;
        tick();
        lsu_new_ctrl_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            data_gnt_i    = (c == 1);
            data_rvalid_i = (c == 2);
            data_rdata_i  = 32'h0BAD_F00D;
            if (rf_wb_o === 1'b1 && wb_cycle < 0) wb_cycle = c;
            tick();
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        n_checks++;
        if (wb_cycle != 3) begin
            n_fail++;
            $display("FAIL load_latency: writeback at cycle %0d, required 3", wb_cycle);
        end
    endtask

    task automatic test_timeout();
        lsu_new_ctrl_i = 1'b1; lsu_ctrl_i = 4'b0010; lsu_addr_i = 32'h500;
        tick();
        lsu_new_ctrl_i = 1'b0;
        for (int c = 0; c < TO; c++) begin
            n_checks++;
            if (data_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold c%0d: req=%b err=%b, required 1 0", c, data_req_o, bus_err_o);
            end
            tick();
        end
        n_checks++;
        if (data_req_o !== 1'b0 || bus_err_o !== 1'b1 || lsu_busy_o !== 1'b0 || rf_wb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: req=%b err=%b busy=%b wb=%b, required 0 1 0 0", data_req_o, bus_err_o, lsu_busy_o, rf_wb_o);
        end
        tick();
        n_checks++;
        if (bus_err_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err=%b busy=%b, required 0 0", bus_err_o, lsu_busy_o);
        end
    endtask

    task automatic test_err_then_reset();
        do_txn("lw_err", 1'b0, 2, 5'd12, 32'h600, 32'h0, 32'h1111_2222, 0, 0, 1'b1, 1'b0);
        lsu_new_ctrl_i = 1'b1; lsu_ctrl_i = 4'b0010; lsu_addr_i = 32'h704; lsu_regdest_i = 5'd13;
        tick();
        lsu_new_ctrl_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check_all_zero("reset_mid_req");
        rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA; data_gnt_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
        tick();
        n_checks++;
        if (rf_wb_o !== 1'b0 || bus_err_o !== 1'b0 || lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_rvalid: wb=%b err=%b busy=%b req=%b, required 0 0 0 0", rf_wb_o, bus_err_o, lsu_busy_o, data_req_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          st    = $urandom_range(0, 1);
            int          pick  = $urandom_range(0, 9);
            int          f3;
            logic [31:0] a     = $urandom;
            int          gd    = $urandom_range(0, 1);
            int          rvd   = (gd == 0) ? int'($urandom_range(0, 1)) : 0;
            bit          err   = ($urandom_range(0, 7) == 0);
            bit          noise = $urandom_range(0, 1);
            string       nm;
            if (pick >= 8) f3 = 3 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1); // 3, 4..7 region
            else if (st)   f3 = $urandom_range(0, 2);
            else           f3 = (pick < 5) ? pick : $urandom_range(0, 2);
            if (st && (f3 == 4 || f3 == 5)) f3 = f3 - 4;
            if (pick >= 8 && f3 != 3 && f3 != 6 && f3 != 7) f3 = 7;
            // Bias toward aligned addresses so most picks reach the bus.
            if ($urandom_range(0, 3) != 0) a = a & ~(32'((f3 % 4 == 2) ? 3 : (f3 % 4 == 1) ? 1 : 0));
            nm = $sformatf("rnd%0d", n);
            if (m_misaligned(f3, a)) do_misaligned(nm, st, f3, a);
            else do_txn(nm, st, f3, 5'($urandom), a, $urandom, $urandom, gd, rvd, err, noise);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_timeout();
        test_err_then_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
